// File: rtl/regfile_uart_dump.sv
// rtl/regfile_uart_dump.sv - dumps all 32 register-file words over an 8N1 UART line
//
// Ports:
//   clock            system clock, rising-edge active
//   reset            asynchronous active-low reset
//   dump_start       request a full dump (accepted only while idle)
//   rf_read_register register index presented to the register-file read port
//   rf_read_data     combinational read data for rf_read_register
//   tx               UART serial output, idle high
//   busy             high while a dump is in progress
//   done             one-cycle pulse when the dump completes
//
// Each word is sent as four frames, most significant byte first, each frame
// LSB first. Words go out in index order 0..31.

module regfile_uart_dump #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dump_start,
    output logic [4:0]  rf_read_register,
    input  logic [31:0] rf_read_data,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  baud_cnt;
    logic [2:0]        bit_cnt;
    logic [1:0]        byte_idx;
    logic [4:0]        word_idx;
    logic [31:0]       shift_word;

    logic              bit_end;
    logic              last_byte;
    logic              last_word;
    logic [7:0]        cur_byte;

    assign bit_end   = (baud_cnt == BAUD_LAST);
    assign last_byte = (byte_idx == 2'd3);
    assign last_word = (word_idx == 5'd31);
    // The byte on the wire always sits in the top of the shift word; it is
    // shifted up by a byte after each frame of the same word.
    assign cur_byte  = shift_word[31:24];

    assign rf_read_register = word_idx;

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (dump_start) state_next = S_LOAD;
            S_LOAD:  state_next = S_START;
            S_START: if (bit_end) state_next = S_DATA;
            S_DATA:  if (bit_end && bit_cnt == 3'd7) state_next = S_STOP;
            S_STOP: begin
                if (bit_end) begin
                    if (!last_byte) begin
                        state_next = S_START;
                    end else if (!last_word) begin
                        state_next = S_LOAD;
                    end else begin
                        state_next = S_DONE;
                    end
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        tx   = 1'b1;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            S_IDLE:  ;
            S_LOAD:  busy = 1'b1;
            S_START: begin
                busy = 1'b1;
                tx   = 1'b0;
            end
            S_DATA: begin
                busy = 1'b1;
                tx   = cur_byte[bit_cnt];
            end
            S_STOP:  busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    // Datapath: baud/bit counters, byte/word indices and the shift word
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            baud_cnt   <= '0;
            bit_cnt    <= 3'd0;
            byte_idx   <= 2'd0;
            word_idx   <= 5'd0;
            shift_word <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dump_start) begin
                        baud_cnt <= '0;
                        bit_cnt  <= 3'd0;
                        byte_idx <= 2'd0;
                        word_idx <= 5'd0;
                    end
                end
                S_LOAD: begin
                    shift_word <= rf_read_data;
                    baud_cnt   <= '0;
                    bit_cnt    <= 3'd0;
                end
                S_START: begin
                    baud_cnt <= bit_end ? '0 : baud_cnt + 1'b1;
                    bit_cnt  <= 3'd0;
                end
                S_DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_cnt  <= bit_cnt + 3'd1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (!last_byte) begin
                            byte_idx   <= byte_idx + 2'd1;
                            shift_word <= {shift_word[23:0], 8'd0};
                        end else if (!last_word) begin
                            byte_idx <= 2'd0;
                            word_idx <= word_idx + 5'd1;
                        end else begin
                            // Leave the read port at register 0 once finished.
                            byte_idx   <= 2'd0;
                            word_idx   <= 5'd0;
                            shift_word <= 32'd0;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DONE: ;
                default: ;
            endcase
        end
    end

endmodule
